// File: rtl/la_ibuf_filt.sv
// Multi-channel pad input buffer: raw gated pass-through plus a synchronized,
// debounced level with one-cycle rise/fall pulses per channel.
module la_ibuf_filt #(
  parameter int N    = 1,
  parameter int SYNC = 2,
  parameter int FILT = 4,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ie,
  input  logic [N-1:0] in,
  output logic [N-1:0] z,
  output logic [N-1:0] zf,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  logic [N-1:0] g;

  assign g = in & ie;
  assign z = g;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC-1:0] sync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zf_q, zf_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            y;
    logic            upd;

    assign y = sync_q[SYNC-1];

    // A differing level must be seen FILT cycles in a row; any match restarts.
    always_comb begin
      cnt_d = cnt_q;
      zf_d  = zf_q;
      upd   = 1'b0;
      if (y == zf_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        zf_d  = y;
        cnt_d = '0;
        upd   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      rise_d = upd & y;
      fall_d = upd & ~y;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '0;
        cnt_q  <= '0;
        zf_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC-2:0], g[i]};
        cnt_q  <= cnt_d;
        zf_q   <= zf_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign zf[i]   = zf_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

endmodule

// File: tb/tb_la_ibuf_filt.sv
// Bench for la_ibuf_filt: a 4-channel SYNC=2/FILT=4 instance and a 1-channel
// SYNC=3/FILT=1 instance, checked every cycle against a window-based model.
module tb_la_ibuf_filt;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ie, in, z, zf, rise, fall;
  logic       ie_b, in_b, z_b, zf_b, rise_b, fall_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  la_ibuf_filt #(.N(4), .SYNC(2), .FILT(4), .PROP("DEFAULT")) dut_a (
    .clk(clk), .reset(reset), .ie(ie), .in(in),
    .z(z), .zf(zf), .rise(rise), .fall(fall)
  );

  la_ibuf_filt #(.N(1), .SYNC(3), .FILT(1), .PROP("DEFAULT")) dut_b (
    .clk(clk), .reset(reset), .ie(ie_b), .in(in_b),
    .z(z_b), .zf(zf_b), .rise(rise_b), .fall(fall_b)
  );

  // Reference model: channels 0..3 belong to dut_a, channel 4 to dut_b.
  // A channel accepts a new level when the synced value seen at each of the
  // last FILT edges differs from the current filtered level.
  int         sync_p [5] = '{2, 2, 2, 2, 3};
  int         filt_p [5] = '{4, 4, 4, 4, 1};
  bit         ghist  [5][4096];
  int         k_edge = 0;
  logic [4:0] m_zf   = '0;
  logic [4:0] m_rise = '0;
  logic [4:0] m_fall = '0;

  task automatic model_edge();
    if (reset) begin
      k_edge = 0;
      m_zf   = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      k_edge++;
      for (int ch = 0; ch < 5; ch++) begin
        bit upd;
        ghist[ch][k_edge] = (ch < 4) ? (in[ch] & ie[ch]) : (in_b & ie_b);
        upd = (k_edge >= filt_p[ch]);
        for (int j = k_edge - filt_p[ch] + 1; j <= k_edge; j++) begin
          bit yu;
          yu = (j - sync_p[ch] >= 1) ? ghist[ch][j - sync_p[ch]] : 1'b0;
          if (j >= 1 && yu == m_zf[ch]) upd = 1'b0;
        end
        m_rise[ch] = upd & ~m_zf[ch];
        m_fall[ch] = upd & m_zf[ch];
        if (upd) m_zf[ch] = ~m_zf[ch];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("z_a",    z,               in & ie);
    chk("zf_a",   zf,              m_zf[3:0]);
    chk("rise_a", rise,            m_rise[3:0]);
    chk("fall_a", fall,            m_fall[3:0]);
    chk("z_b",    {3'b0, z_b},     {3'b0, in_b & ie_b});
    chk("zf_b",   {3'b0, zf_b},    {3'b0, m_zf[4]});
    chk("rise_b", {3'b0, rise_b},  {3'b0, m_rise[4]});
    chk("fall_b", {3'b0, fall_b},  {3'b0, m_fall[4]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic saw;

    // Reset with every pad asserted.
    reset = 1'b1; in = 4'hF; ie = 4'hF; in_b = 1'b1; ie_b = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("rst_zf", zf, 4'h0);
      chk("rst_z",  z,  4'hF);
    end

    // Straps asserted at release are detected.
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 6)  chk("strap_zf_early", zf, 4'h0);
      if (e == 6) chk("strap_zf",   zf,   4'hF);
      if (e == 6) chk("strap_rise", rise, 4'hF);
      if (e == 7) chk("strap_rise_one_cycle", rise, 4'h0);
      if (e == 3) chk("b_zf_early", {3'b0, zf_b},   4'h0);
      if (e == 4) chk("b_zf_edge4", {3'b0, zf_b},   4'h1);
      if (e == 4) chk("b_rise",     {3'b0, rise_b}, 4'h1);
    end

    // Channel 0: bring to 0, then a 3-cycle glitch must be rejected.
    in = 4'hE;
    for (int e = 0; e < 8; e++) tick();
    chk("ch0_low", {3'b0, zf[0]}, 4'h0);
    saw = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      in[0] = (e <= 3);
      tick();
      saw |= rise[0];
    end
    chk("ch0_glitch3_rise", {3'b0, saw},   4'h0);
    chk("ch0_glitch3_zf",   {3'b0, zf[0]}, 4'h0);

    // Channel 0: a 4-cycle pulse is accepted, then its return to 0.
    for (int e = 1; e <= 12; e++) begin
      in[0] = (e <= 4);
      tick();
      if (e == 5)  chk("ch0_p4_zf_e5",  {3'b0, zf[0]},   4'h0);
      if (e == 6)  chk("ch0_p4_rise",   {3'b0, rise[0]}, 4'h1);
      if (e == 9)  chk("ch0_p4_zf_e9",  {3'b0, zf[0]},   4'h1);
      if (e == 10) chk("ch0_p4_fall",   {3'b0, fall[0]}, 4'h1);
      if (e == 10) chk("ch0_p4_zf_e10", {3'b0, zf[0]},   4'h0);
    end

    // Channel 1: per-cycle chatter never drops a held 1.
    saw = 1'b0;
    for (int e = 0; e < 28; e++) begin
      in[1] = (e >= 20) || (e % 2 == 1);
      tick();
      saw |= fall[1];
    end
    chk("ch1_chatter_fall", {3'b0, saw},   4'h0);
    chk("ch1_chatter_zf",   {3'b0, zf[1]}, 4'h1);

    // Channel 2: dropping the enable gates z at once and zf after latency.
    ie[2] = 1'b0;
    #1;
    chk("ch2_z_gated", {3'b0, z[2]}, 4'h0);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("ch2_zf_e5",  {3'b0, zf[2]},   4'h1);
      if (e == 6) chk("ch2_zf_e6",  {3'b0, zf[2]},   4'h0);
      if (e == 6) chk("ch2_fall",   {3'b0, fall[2]}, 4'h1);
    end

    // Channel 3: reset in the middle of a rising count discards it.
    in[3] = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    in[3] = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_zf",   zf,   4'h0);
    chk("mid_rst_rise", rise, 4'h0);
    reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("ch3_zf_e5",  {3'b0, zf[3]},   4'h0);
      if (e == 6) chk("ch3_zf_e6",  {3'b0, zf[3]},   4'h1);
      if (e == 6) chk("ch3_rise",   {3'b0, rise[3]}, 4'h1);
    end

    // Randomized traffic with occasional resets, checked by the model.
    for (int t = 0; t < 600; t++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) in[b] = ~in[b];
      if ($urandom_range(0, 24) == 0) ie = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) in_b = ~in_b;
      if ($urandom_range(0, 15) == 0) ie_b = ~ie_b;
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
